// File: rtl/ahb_decoder_mux.sv
// rtl/ahb_decoder_mux.sv - AHB-Lite address decoder and response mux with error tracking
module ahb_decoder_mux #(
   parameter int NUM_SLAVES    = 4,
   parameter int ADDR_WIDTH    = 32,
   parameter int DATA_WIDTH    = 32,
   parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_BASE =
      {32'h4000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000},
   parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_MASK = {4{32'hF000_0000}},
   parameter int ERR_CNT_WIDTH = 8
) (
   input  logic                             HCLK,
   input  logic                             HRESET,
   input  logic [ADDR_WIDTH-1:0]            HADDR,
   input  logic [1:0]                       HTRANS,
   output logic [NUM_SLAVES-1:0]            HSEL,
   output logic                             HSELDefault,
   input  logic [NUM_SLAVES-1:0]            HREADYOUT_S,
   input  logic [2*NUM_SLAVES-1:0]          HRESP_S,
   input  logic [DATA_WIDTH*NUM_SLAVES-1:0] HRDATA_S,
   input  logic                             HREADYDefault,
   input  logic [1:0]                       HRESPDefault,
   output logic                             HREADY,
   output logic [1:0]                       HRESP,
   output logic [DATA_WIDTH-1:0]            HRDATA,
   output logic [ERR_CNT_WIDTH-1:0]         err_count,
   output logic [ADDR_WIDTH-1:0]            err_addr
);

   localparam logic [1:0] RESP_OKAY  = 2'b00;
   localparam logic [1:0] RESP_ERROR = 2'b01;

   // Data-phase owner: one-hot slave vector plus default flag; all zero means NONE.
   logic [NUM_SLAVES-1:0]    r_dsel;
   logic                     r_ddef;
   logic [ADDR_WIDTH-1:0]    r_addr_dp;
   logic [ERR_CNT_WIDTH-1:0] r_err_count;
   logic [ADDR_WIDTH-1:0]    r_err_addr;

   logic [NUM_SLAVES-1:0]    w_hsel;
   logic                     w_hit;
   logic                     w_active;
   logic                     w_err_done;
   logic [NUM_SLAVES-1:0]    w_dsel_nxt;
   logic                     w_ddef_nxt;
   logic [ADDR_WIDTH-1:0]    w_addr_nxt;
   logic [ERR_CNT_WIDTH-1:0] w_cnt_nxt;
   logic [ADDR_WIDTH-1:0]    w_eaddr_nxt;

   // Priority decode: the first matching region blocks all higher indices.
   always_comb begin
      w_hsel = '0;
      w_hit  = 1'b0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         if (!w_hit &&
             ((HADDR & SLAVE_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) ==
              SLAVE_BASE[i*ADDR_WIDTH +: ADDR_WIDTH])) begin
            w_hsel[i] = 1'b1;
            w_hit     = 1'b1;
         end
      end
   end

   assign HSEL        = w_hsel;
   assign HSELDefault = ~w_hit;

   always_comb begin
      HREADY = 1'b1;
      HRESP  = RESP_OKAY;
      HRDATA = '0;
      if (r_ddef) begin
         HREADY = HREADYDefault;
         HRESP  = HRESPDefault;
      end
      for (int i = 0; i < NUM_SLAVES; i++) begin
         if (r_dsel[i]) begin
            HREADY = HREADYOUT_S[i];
            HRESP  = HRESP_S[2*i +: 2];
            HRDATA = HRDATA_S[DATA_WIDTH*i +: DATA_WIDTH];
         end
      end
   end

   assign w_active   = (HTRANS == 2'b10) || (HTRANS == 2'b11);
   assign w_err_done = HREADY && (HRESP == RESP_ERROR);

   always_comb begin
      w_dsel_nxt  = r_dsel;
      w_ddef_nxt  = r_ddef;
      w_addr_nxt  = r_addr_dp;
      w_cnt_nxt   = r_err_count;
      w_eaddr_nxt = r_err_addr;
      if (HREADY) begin
         w_addr_nxt = HADDR;
         if (w_active) begin
            w_dsel_nxt = w_hsel;
            w_ddef_nxt = ~w_hit;
         end else begin
            w_dsel_nxt = '0;
            w_ddef_nxt = 1'b0;
         end
      end
      if (w_err_done) begin
         if (r_err_count != '1) begin
            w_cnt_nxt = r_err_count + ERR_CNT_WIDTH'(1);
         end
         w_eaddr_nxt = r_addr_dp;
      end
   end

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         r_dsel      <= '0;
         r_ddef      <= 1'b0;
         r_addr_dp   <= '0;
         r_err_count <= '0;
         r_err_addr  <= '0;
      end else begin
         r_dsel      <= w_dsel_nxt;
         r_ddef      <= w_ddef_nxt;
         r_addr_dp   <= w_addr_nxt;
         r_err_count <= w_cnt_nxt;
         r_err_addr  <= w_eaddr_nxt;
      end
   end

   assign err_count = r_err_count;
   assign err_addr  = r_err_addr;

endmodule

// File: tb/tb_ahb_decoder_mux.sv
// tb/tb_ahb_decoder_mux.sv - directed vector bench for ahb_decoder_mux
module tb_ahb_decoder_mux;

   logic         HCLK;
   logic         HRESET;
   logic [31:0]  HADDR;
   logic [1:0]   HTRANS;
   logic [3:0]   HSEL;
   logic         HSELDefault;
   logic [3:0]   HREADYOUT_S;
   logic [7:0]   HRESP_S;
   logic [127:0] HRDATA_S;
   logic         HREADYDefault;
   logic [1:0]   HRESPDefault;
   logic         HREADY;
   logic [1:0]   HRESP;
   logic [31:0]  HRDATA;
   logic [7:0]   err_count;
   logic [31:0]  err_addr;

   logic [3:0]   w2_hsel;
   logic         w2_hseldef;
   logic         w2_hready;
   logic [1:0]   w2_hresp;
   logic [31:0]  w2_hrdata;
   logic [7:0]   w2_err_count;
   logic [31:0]  w2_err_addr;

   int n_vec = 0;
   int n_bad = 0;

   ahb_decoder_mux dut (
      .HCLK(HCLK), .HRESET(HRESET), .HADDR(HADDR), .HTRANS(HTRANS),
      .HSEL(HSEL), .HSELDefault(HSELDefault),
      .HREADYOUT_S(HREADYOUT_S), .HRESP_S(HRESP_S), .HRDATA_S(HRDATA_S),
      .HREADYDefault(HREADYDefault), .HRESPDefault(HRESPDefault),
      .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA),
      .err_count(err_count), .err_addr(err_addr)
   );

   // Overlapping map: slave1 matches everything, so only slave0 can beat it.
   ahb_decoder_mux #(
      .SLAVE_BASE({32'h4000_0000, 32'h2000_0000, 32'h0000_0000, 32'h0000_0000}),
      .SLAVE_MASK({32'hF000_0000, 32'hF000_0000, 32'h0000_0000, 32'hF000_0000})
   ) dut_ovl (
      .HCLK(HCLK), .HRESET(HRESET), .HADDR(HADDR), .HTRANS(HTRANS),
      .HSEL(w2_hsel), .HSELDefault(w2_hseldef),
      .HREADYOUT_S(HREADYOUT_S), .HRESP_S(HRESP_S), .HRDATA_S(HRDATA_S),
      .HREADYDefault(HREADYDefault), .HRESPDefault(HRESPDefault),
      .HREADY(w2_hready), .HRESP(w2_hresp), .HRDATA(w2_hrdata),
      .err_count(w2_err_count), .err_addr(w2_err_addr)
   );

   initial HCLK = 1'b0;
   always #5 HCLK = ~HCLK;

   typedef struct {
      logic [31:0] haddr;
      logic [1:0]  htrans;
      logic [3:0]  exp_hsel;
      logic        exp_def;
      logic        exp_ready;
      logic [1:0]  exp_resp;
      logic [31:0] exp_rdata;
      logic [3:0]  exp_hsel2;
   } vec_t;

   vec_t vecs[9];

   task automatic tick();
      @(posedge HCLK);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   initial begin
      // Every vector sees the routing of the previous accepted address phase.
      vecs[0] = '{32'h0000_0010, 2'b10, 4'b0001, 1'b0, 1'b1, 2'b00, 32'h0000_0000, 4'b0001};
      vecs[1] = '{32'h1000_0000, 2'b11, 4'b0010, 1'b0, 1'b1, 2'b00, 32'hD000_0000, 4'b0010};
      vecs[2] = '{32'h2FFF_FFFC, 2'b10, 4'b0100, 1'b0, 1'b1, 2'b00, 32'hD000_0001, 4'b0010};
      vecs[3] = '{32'h4000_0000, 2'b10, 4'b1000, 1'b0, 1'b1, 2'b00, 32'hD000_0002, 4'b0010};
      vecs[4] = '{32'h5000_0000, 2'b10, 4'b0000, 1'b1, 1'b1, 2'b00, 32'hD000_0003, 4'b0010};
      vecs[5] = '{32'h3000_0000, 2'b00, 4'b0000, 1'b1, 1'b1, 2'b00, 32'h0000_0000, 4'b0010};
      vecs[6] = '{32'h4000_0000, 2'b01, 4'b1000, 1'b0, 1'b1, 2'b00, 32'h0000_0000, 4'b0010};
      vecs[7] = '{32'hF000_0000, 2'b10, 4'b0000, 1'b1, 1'b1, 2'b00, 32'h0000_0000, 4'b0010};
      vecs[8] = '{32'h0000_0000, 2'b00, 4'b0001, 1'b0, 1'b1, 2'b00, 32'h0000_0000, 4'b0001};

      HRESET        = 1'b1;
      HTRANS        = 2'b10;
      HADDR         = 32'h1000_0000;
      HREADYOUT_S   = 4'b1111;
      HRESP_S       = 8'h00;
      HRDATA_S      = {32'hD000_0003, 32'hD000_0002, 32'hD000_0001, 32'hD000_0000};
      HREADYDefault = 1'b1;
      HRESPDefault  = 2'b00;

      // Reset held for two edges with a live NONSEQ on the bus
      tick();
      tick();
      HRESET = 1'b0;
      HTRANS = 2'b00;
      #1;
      check("reset_hready", 64'(HREADY), 64'd1);
      check("reset_hresp", 64'(HRESP), 64'd0);
      check("reset_err_count", 64'(err_count), 64'd0);
      check("reset_err_addr", 64'(err_addr), 64'd0);
      tick();

      for (int v = 0; v < 9; v++) begin
         HADDR  = vecs[v].haddr;
         HTRANS = vecs[v].htrans;
         #1;
         check($sformatf("vec%0d", v),
               64'({HSEL, HSELDefault, HREADY, HRESP, HRDATA}),
               64'({vecs[v].exp_hsel, vecs[v].exp_def, vecs[v].exp_ready,
                    vecs[v].exp_resp, vecs[v].exp_rdata}));
         check($sformatf("vec%0d_overlap", v), 64'({w2_hsel, w2_hseldef}),
               64'({vecs[v].exp_hsel2, 1'b0}));
         tick();
      end
      HTRANS = 2'b00;
      tick();

      // Wait states from slave1
      HADDR  = 32'h1000_0040;
      HTRANS = 2'b10;
      #1;
      check("ws_hsel", 64'(HSEL), 64'h2);
      tick();
      HTRANS         = 2'b00;
      HREADYOUT_S[1] = 1'b0;
      #1;
      check("ws_wait1", 64'(HREADY), 64'd0);
      tick();
      check("ws_wait2", 64'(HREADY), 64'd0);
      tick();
      HREADYOUT_S[1]   = 1'b1;
      HRDATA_S[63:32]  = 32'hCAFE_F00D;
      #1;
      check("ws_done", 64'({HREADY, HRDATA}), 64'({1'b1, 32'hCAFE_F00D}));
      tick();

      // Unmapped address: two-cycle ERROR from the default slave
      HADDR  = 32'h8000_0000;
      HTRANS = 2'b10;
      #1;
      check("unmapped_sel", 64'({HSEL, HSELDefault}), 64'({4'b0000, 1'b1}));
      tick();
      HADDR         = 32'h0000_0000;
      HREADYDefault = 1'b0;
      HRESPDefault  = 2'b01;
      #1;
      check("err_first_cycle", 64'({HREADY, HRESP}), 64'({1'b0, 2'b01}));
      tick();
      HREADYDefault = 1'b1;
      #1;
      check("err_second_cycle", 64'({HREADY, HRESP}), 64'({1'b1, 2'b01}));
      tick();
      HTRANS       = 2'b00;
      HRESPDefault = 2'b00;
      #1;
      check("err_count_1", 64'(err_count), 64'd1);
      check("err_addr_1", 64'(err_addr), 64'h8000_0000);
      tick();

      // Pipelining: slave2 address phase held behind slave0's wait state
      HADDR  = 32'h0000_0000;
      HTRANS = 2'b10;
      tick();
      HADDR          = 32'h2000_0004;
      HREADYOUT_S[0] = 1'b0;
      #1;
      check("pipe_stall", 64'({HREADY, HSEL}), 64'({1'b0, 4'b0100}));
      tick();
      HREADYOUT_S[0] = 1'b1;
      HRDATA_S[31:0] = 32'h1111_0000;
      #1;
      check("pipe_s0_data", 64'({HREADY, HRDATA}), 64'({1'b1, 32'h1111_0000}));
      tick();
      HTRANS          = 2'b00;
      HRDATA_S[95:64] = 32'h2222_0002;
      #1;
      check("pipe_s2_data", 64'({HREADY, HRDATA}), 64'({1'b1, 32'h2222_0002}));
      tick();

      // IDLE to slave3: select shown, but slave3's data phase is ignored
      HADDR  = 32'h4000_0000;
      HTRANS = 2'b00;
      #1;
      check("idle_hsel", 64'(HSEL), 64'h8);
      tick();
      HREADYOUT_S[3] = 1'b0;
      HRESP_S[7:6]   = 2'b01;
      #1;
      check("idle_ignored", 64'({HREADY, HRESP, HRDATA}), 64'({1'b1, 2'b00, 32'h0}));
      HREADYOUT_S[3] = 1'b1;
      HRESP_S[7:6]   = 2'b00;
      tick();

      // Saturation: single-cycle ERRORs from the default slave every cycle
      HADDR         = 32'h9000_0000;
      HTRANS        = 2'b10;
      HREADYDefault = 1'b1;
      HRESPDefault  = 2'b01;
      for (int k = 0; k < 254; k++) tick();
      check("err_count_254", 64'(err_count), 64'd254);
      for (int k = 0; k < 47; k++) tick();
      check("err_count_sat", 64'(err_count), 64'd255);
      check("err_addr_sat", 64'(err_addr), 64'h9000_0000);
      HTRANS = 2'b00;
      tick();
      HRESPDefault = 2'b00;

      // Reset in the middle of a stalled slave1 ERROR
      HADDR  = 32'h1000_0000;
      HTRANS = 2'b10;
      tick();
      HTRANS         = 2'b00;
      HREADYOUT_S[1] = 1'b0;
      HRESP_S[3:2]   = 2'b01;
      #1;
      check("stall_before_reset", 64'(HREADY), 64'd0);
      HRESET = 1'b1;
      tick();
      HRESET = 1'b0;
      #1;
      check("after_reset_route", 64'({HREADY, HRESP}), 64'({1'b1, 2'b00}));
      check("after_reset_err", 64'({err_count, err_addr}), 64'({8'd0, 32'h0}));
      tick();
      check("no_err_after_reset", 64'(err_count), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
